nios2_oci_trace_ctrl: RTL

Capture controller for the Nios II on-chip debug trace path. It accepts compressed-trace frames (`dct_buffer`/`dct_count`) from the OCI trace packer and sequences them into a shared single-port trace RAM through an arm, trigger, post-trigger and done capture cycle. Once capture has stopped, it hands the same RAM port to the JTAG debug host for readback. It sits between the OCI trace packer and the trace memory inside the Nios II debug module.

---
 rtl/nios2_oci_trace_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/nios2_oci_trace_ctrl.sv
// Trace capture controller: sequences packer frames into the trace RAM across an
// arm/trigger/post-trigger/done cycle, then lends the RAM port to host readback.
module nios2_oci_trace_ctrl #(
    parameter int ADDR_W     = 7,
    parameter int POST_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dct_valid,
    input  logic [29:0]       dct_buffer,
    input  logic [3:0]        dct_count,
    input  logic              arm,
    input  logic              trigger,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [35:0]       mem_q,
    output logic              mem_wren,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [35:0]       mem_wdata,
    output logic              rd_valid,
    output logic [35:0]       rd_data,
    output logic              rd_err,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              wrapped,
    output logic [1:0]        state,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] POST_INIT = ADDR_W'(POST_DEPTH);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam bit                POST_ZERO = (POST_DEPTH == 0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              wrapped_q, wrapped_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic              first_q, first_d;
    logic              mem_wren_q, mem_wren_d;
    logic              mem_rden_q, mem_rden_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [35:0]       mem_wdata_q, mem_wdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_err_q, rd_err_d;

    logic capturing;
    logic accept;
    logic rd_ok;
    logic trig_take;

    always_comb begin
        capturing = (state_q == S_ARMED) || (state_q == S_POST);
        // arm has priority over everything in its cycle: frames and reads are dropped
        accept    = dct_valid && (dct_count != 4'd0) && capturing && !arm;
        rd_ok     = rd_req && !capturing && !arm;
        trig_take = (state_q == S_ARMED) && trigger && !arm;

        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wrapped_d   = wrapped_q;
        post_cnt_d  = post_cnt_q;
        first_d     = first_q;
        mem_wren_d  = accept;
        mem_rden_d  = rd_ok;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_valid_d  = mem_rden_q;
        rd_err_d    = rd_req && !rd_ok;

        if (accept) begin
            mem_addr_d  = wr_ptr_q;
            mem_wdata_d = {trig_take, first_q, dct_count, dct_buffer};
        end else if (rd_ok) begin
            mem_addr_d = rd_addr;
        end

        if (arm) begin
            state_d    = S_ARMED;
            wr_ptr_d   = '0;
            wrapped_d  = 1'b0;
            first_d    = 1'b1;
            post_cnt_d = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + ONE;
                first_d  = 1'b0;
                if (wr_ptr_q == '1) begin
                    wrapped_d = 1'b1;
                end
            end
            case (state_q)
                S_ARMED: begin
                    if (trigger) begin
                        if (POST_ZERO) begin
                            state_d = S_DONE;
                        end else begin
                            state_d    = S_POST;
                            post_cnt_d = POST_INIT;
                        end
                    end
                end
                S_POST: begin
                    // the trigger frame itself is not counted; only later frames are
                    if (accept) begin
                        post_cnt_d = post_cnt_q - ONE;
                        if (post_cnt_q == ONE) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            wrapped_q   <= 1'b0;
            post_cnt_q  <= '0;
            first_q     <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_rden_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wrapped_q   <= wrapped_d;
            post_cnt_q  <= post_cnt_d;
            first_q     <= first_d;
            mem_wren_q  <= mem_wren_d;
            mem_rden_q  <= mem_rden_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_valid_q  <= rd_valid_d;
            rd_err_q    <= rd_err_d;
        end
    end

    assign mem_wren  = mem_wren_q;
    assign mem_rden  = mem_rden_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = mem_q;
    assign rd_err    = rd_err_q;
    assign wr_ptr    = wr_ptr_q;
    assign wrapped   = wrapped_q;
    assign state     = state_q;
    assign done      = (state_q == S_DONE);

endmodule
